fifo_rr_drain_arb: RTL and testbench

Round-robin drain scheduler that shares one downstream channel among NUM_CH show-ahead synchronous FIFOs in the ACE PCIe-host bridge. It grants one FIFO at a time, pops it beat-by-beat into a registered output stage with a valid/ready handshake, and holds the grant until packet end or a beat cap. It then rotates priority. It sits between the per-requester sync FIFOs and the shared host-bound datapath.

---
 rtl/fifo_rr_drain_arb_pkg.sv | 20 ++
 rtl/rr_arb_pick.sv | 32 +++
 rtl/fifo_rr_drain_arb.sv | 110 +++++++++++
 tb/tb_fifo_rr_drain_arb.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_drain_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO drain scheduler and its
// rotate-priority picker.
package fifo_rr_drain_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index width for n items; never returns zero so 1-entry cases stay legal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Next channel index in a ring of n channels.
  function automatic int wrap_inc(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational rotate-priority encoder: first set bit of req at or above
// rr_ptr, wrapping to bit 0. Reusable by any bridge scheduler.
module rr_arb_pick
  import fifo_rr_drain_arb_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int IDX_W  = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic              found,
  output logic [IDX_W-1:0]  idx
);

  logic [IDX_W-1:0] cand;

  // NOTE: every variable written here gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = rr_ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = IDX_W'(wrap_inc(int'(cand), NUM_CH));
    end
  end

endmodule

// File: rtl/fifo_rr_drain_arb.sv
// Round-robin drain scheduler: grants one show-ahead FIFO at a time, pops it
// into a registered valid/ready output stage until packet end or beat cap.
module fifo_rr_drain_arb
  import fifo_rr_drain_arb_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int WIDTH     = 64,
  parameter  int MAX_BEATS = 16,
  localparam int IDX_W     = clog2_min1(NUM_CH),
  localparam int CNT_W     = clog2_min1(MAX_BEATS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       ch_rden,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [IDX_W-1:0]        out_ch,
  output logic                    out_last,
  output logic                    busy
);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] gnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic [NUM_CH-1:0] req;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic [WIDTH-1:0]  head;
  logic              pop;
  logic              beat_end;

  // Mask only matters at arbitration; a locked grant ignores ch_en.
  assign req  = ch_valid & ch_en;
  assign head = ch_data[int'(gnt)*WIDTH +: WIDTH];
  assign busy = (state == GRANT);

  rr_arb_pick #(
    .NUM_CH (NUM_CH)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    beat_end  = 1'b0;
    ch_rden   = '0;
    case (state)
      IDLE: begin
        if (pick_found) state_nxt = GRANT;
      end
      GRANT: begin
        // Pop only when the output stage is empty or draining this cycle.
        pop      = ch_valid[gnt] && (!out_valid || out_ready);
        beat_end = head[WIDTH-1] || (beat_cnt == CNT_W'(MAX_BEATS - 1));
        if (pop) begin
          ch_rden[gnt] = 1'b1;
          if (beat_end) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: out_data is a single register, not storage, so it is reset too;
  // downstream never sees stale data from an aborted packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE && pick_found) begin
        gnt      <= pick_idx;
        beat_cnt <= '0;
      end
      if (pop) begin
        out_data  <= head;
        out_ch    <= gnt;
        out_valid <= 1'b1;
        out_last  <= beat_end;
        beat_cnt  <= beat_cnt + CNT_W'(1);
        if (beat_end) rr_ptr <= IDX_W'(wrap_inc(int'(gnt), NUM_CH));
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain_arb.sv
// Directed bench for fifo_rr_drain_arb: show-ahead FIFO models feed the DUT,
// accepted beats are logged and compared against hand-written expectations.
module tb_fifo_rr_drain_arb;

  localparam int NUM_CH    = 4;
  localparam int WIDTH     = 64;
  localparam int MAX_BEATS = 16;
  localparam int DEPTH     = 32;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH-1:0]       ch_valid;
  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH-1:0]       ch_rden;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [1:0]              out_ch;
  logic                    out_last;
  logic                    busy;

  always #5 clk = ~clk;

  fifo_rr_drain_arb #(
    .NUM_CH    (NUM_CH),
    .WIDTH     (WIDTH),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_valid  (ch_valid),
    .ch_data   (ch_data),
    .ch_en     (ch_en),
    .ch_rden   (ch_rden),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .busy      (busy)
  );

  // Show-ahead FIFO models; hold[i] forces a channel to look empty.
  logic [WIDTH-1:0]  mem [NUM_CH][DEPTH];
  int                wr_ptr [NUM_CH];
  int                rd_ptr [NUM_CH];
  logic [NUM_CH-1:0] hold;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_valid[i]               = (wr_ptr[i] != rd_ptr[i]) && !hold[i];
      ch_data[i*WIDTH +: WIDTH] = mem[i][rd_ptr[i] % DEPTH];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst_n)          rd_ptr[i] <= wr_ptr[i];
      else if (ch_rden[i]) rd_ptr[i] <= rd_ptr[i] + 1;
    end
  end

  typedef struct {
    int               cyc;
    int               ch;
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  beat_t log_q[$];
  beat_t exp_q[$];
  int    cyc_cnt = 0;
  int    base = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk)
    if (rst_n && out_valid && out_ready)
      log_q.push_back('{cyc_cnt, int'(out_ch), out_data, out_last});

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input int ch, input int seq, input bit last);
    return {last, 47'h0, 8'(ch), 8'(seq)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input int ch, input int n, input int seq0);
    for (int k = 0; k < n; k++) begin
      mem[ch][wr_ptr[ch] % DEPTH] = mk(ch, seq0 + k, k == n - 1);
      wr_ptr[ch] = wr_ptr[ch] + 1;
    end
  endtask

  task automatic exp_beat(input int ch, input int seq, input bit dlast, input bit olast);
    exp_q.push_back('{0, ch, mk(ch, seq, dlast), olast});
  endtask

  task automatic drain_and_compare(input string tag);
    int budget = 200;
    while (log_q.size() - base < exp_q.size() && budget > 0) begin
      step();
      budget--;
    end
    repeat (3) step();
    check({tag, "_count"}, 64'(log_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < log_q.size()) begin
        check({tag, "_ch"},   64'(log_q[base+i].ch), 64'(exp_q[i].ch));
        check({tag, "_data"}, log_q[base+i].data,    exp_q[i].data);
        check({tag, "_last"}, 64'(log_q[base+i].last), 64'(exp_q[i].last));
      end
    end
    base = log_q.size();
    exp_q.delete();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int b0;
    ch_en     = '1;
    out_ready = 1'b1;
    hold      = '0;

    // Reset values
    step();
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_busy",      64'(busy),      0);
    check("rst_rden",      64'(ch_rden),   0);
    check("rst_out_data",  out_data,       0);
    check("rst_out_ch",    64'(out_ch),    0);
    check("rst_out_last",  64'(out_last),  0);
    check("rst_rr_ptr",    64'(dut.rr_ptr), 0);
    step();
    rst_n = 1'b1;
    step();

    // Single channel, 3-beat packet, cycle by cycle
    push_pkt(0, 3, 'h10);
    #1;
    check("t1_c0_rden", 64'(ch_rden), 0);
    check("t1_c0_busy", 64'(busy), 0);
    step();
    check("t1_c1_busy",  64'(busy), 1);
    check("t1_c1_rden",  64'(ch_rden), 'b0001);
    check("t1_c1_valid", 64'(out_valid), 0);
    step();
    check("t1_c2_rden",  64'(ch_rden), 'b0001);
    check("t1_c2_valid", 64'(out_valid), 1);
    check("t1_c2_data",  out_data, mk(0, 'h10, 0));
    check("t1_c2_last",  64'(out_last), 0);
    step();
    check("t1_c3_rden",  64'(ch_rden), 'b0001);
    check("t1_c3_data",  out_data, mk(0, 'h11, 0));
    check("t1_c3_last",  64'(out_last), 0);
    step();
    check("t1_c4_rden",  64'(ch_rden), 0);
    check("t1_c4_busy",  64'(busy), 0);
    check("t1_c4_valid", 64'(out_valid), 1);
    check("t1_c4_data",  out_data, mk(0, 'h12, 1));
    check("t1_c4_ch",    64'(out_ch), 0);
    check("t1_c4_last",  64'(out_last), 1);
    check("t1_rr_ptr",   64'(dut.rr_ptr), 1);
    step();
    check("t1_c5_valid", 64'(out_valid), 0);
    check("t1_count", 64'(log_q.size() - base), 3);
    base = log_q.size();

    // Fairness: two 1-beat packets per channel from rr_ptr 0
    reset_dut();
    for (int c = 0; c < NUM_CH; c++) push_pkt(c, 1, 'h20);
    for (int c = 0; c < NUM_CH; c++) push_pkt(c, 1, 'h21);
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NUM_CH; c++) exp_beat(c, 'h20 + p, 1, 1);
    b0 = base;
    drain_and_compare("fair");
    for (int i = 1; i < 8; i++)
      if (b0 + i < log_q.size())
        check("fair_gap", 64'(log_q[b0+i].cyc - log_q[b0+i-1].cyc), 2);

    // Beat cap: 20-beat packet on ch2 split 16 + 4 around ch3
    push_pkt(2, 20, 'h30);
    push_pkt(3, 1, 'h50);
    for (int k = 0; k < 16; k++) exp_beat(2, 'h30 + k, 0, k == 15);
    exp_beat(3, 'h50, 1, 1);
    for (int k = 16; k < 20; k++) exp_beat(2, 'h30 + k, k == 19, k == 19);
    drain_and_compare("cap");

    // Backpressure: out_ready low for 5 cycles with beat 2 on the output
    push_pkt(1, 5, 'h60);
    step();
    step();
    step();
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_rden",  64'(ch_rden), 0);
      check("bp_valid", 64'(out_valid), 1);
      check("bp_data",  out_data, mk(1, 'h61, 0));
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) exp_beat(1, 'h60 + k, k == 4, k == 4);
    drain_and_compare("bp");

    // Starvation mid-packet plus mask: grant stays on ch1, then ch1 skipped
    push_pkt(1, 4, 'h70);
    step();
    step();
    step();
    hold[1]  = 1'b1;
    ch_en[1] = 1'b0;
    push_pkt(0, 1, 'h80);
    push_pkt(3, 1, 'h90);
    push_pkt(1, 1, 'h78);
    #1;
    for (int k = 0; k < 4; k++) begin
      check("starve_busy", 64'(busy), 1);
      check("starve_rden", 64'(ch_rden), 0);
      step();
    end
    hold[1] = 1'b0;
    for (int k = 0; k < 4; k++) exp_beat(1, 'h70 + k, k == 3, k == 3);
    exp_beat(3, 'h90, 1, 1);
    exp_beat(0, 'h80, 1, 1);
    drain_and_compare("mask");
    check("mask_idle_busy", 64'(busy), 0);
    check("mask_idle_rden", 64'(ch_rden), 0);
    ch_en[1] = 1'b1;
    exp_beat(1, 'h78, 1, 1);
    drain_and_compare("unmask");

    // Reset during beat 3 of a 6-beat packet on ch2 (rr_ptr is 2 here)
    push_pkt(2, 6, 'hA0);
    repeat (4) step();
    check("rst_mid_pre_data", out_data, mk(2, 'hA2, 0));
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid",  64'(out_valid), 0);
    check("rst_mid_busy",   64'(busy), 0);
    check("rst_mid_rr_ptr", 64'(dut.rr_ptr), 0);
    check("rst_mid_rden",   64'(ch_rden), 0);
    check("rst_mid_last",   64'(out_last), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_post_rden", 64'(ch_rden), 0);
    check("rst_post_busy", 64'(busy), 0);
    exp_beat(2, 'hA0, 0, 0);
    exp_beat(2, 'hA1, 0, 0);
    drain_and_compare("rst_mid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
